// File: rtl/morse_rx_decoder.sv
// morse_rx_decoder: turns debounced dot/dash/confirm/backspace keys into
// character codes and maintains a shifting display buffer.
module morse_rx_decoder #(
  parameter int DEPTH      = 8,
  parameter int CHAR_W     = 6,
  parameter int MAX_SYM    = 5,
  parameter int GAP_CYCLES = 50_000_000
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iEnable,
  input  logic [4:0]                iKEY,
  output logic [DEPTH*CHAR_W-1:0]   oDisplayData,
  output logic                      oCharValid,
  output logic [CHAR_W-1:0]         oCharCode,
  output logic [2:0]                oSymCount,
  output logic                      oOverflow,
  output logic                      oBuzzer
);
  localparam int DW = DEPTH * CHAR_W;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CHAR_W-1:0] BLANK = '1;
  localparam logic [CHAR_W-1:0] ERR = {{(CHAR_W-1){1'b1}}, 1'b0};
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;

  logic [4:1]        r_sync1, r_sync2, r_prev;
  logic [0:0]        r_state;
  logic [4:0]        r_stack;
  logic [2:0]        r_count;
  logic [GW-1:0]     r_gap;
  logic              r_ovf, r_valid;
  logic [DW-1:0]     r_disp;
  logic [CHAR_W-1:0] r_code;

  logic [4:1]        w_fall;
  logic              w_dash, w_dot, w_sym, w_conf, w_bs, w_to, w_commit, w_bad;
  logic [5:0]        w_idx;
  logic [CHAR_W-1:0] w_code;

  assign w_fall   = r_prev & ~r_sync2;
  assign w_dash   = iEnable & w_fall[1];
  assign w_dot    = iEnable & w_fall[2] & ~w_fall[1];
  assign w_sym    = w_dash | w_dot;
  assign w_conf   = iEnable & w_fall[3] & ~|w_fall[2:1];
  assign w_bs     = iEnable & w_fall[4] & ~|w_fall[3:1];
  // a confirm landing on the timeout cycle folds into the same single commit
  assign w_to     = iEnable & (r_state == S_COLLECT) & (r_gap == GW'(GAP_CYCLES - 1)) & ~w_sym;
  assign w_commit = w_conf | w_to;

  // dot = 0, dash = 1, first symbol ends up in the highest occupied bit
  always_comb begin
    w_idx = '0;
    w_bad = 1'b0;
    case (r_count)
      3'd1: w_idx = r_stack[0] ? 6'd19 : 6'd4;
      3'd2: case (r_stack[1:0])
        2'b00: w_idx = 6'd8;
        2'b01: w_idx = 6'd0;
        2'b10: w_idx = 6'd13;
        default: w_idx = 6'd12;
      endcase
      3'd3: case (r_stack[2:0])
        3'b000: w_idx = 6'd18;
        3'b001: w_idx = 6'd20;
        3'b010: w_idx = 6'd17;
        3'b011: w_idx = 6'd22;
        3'b100: w_idx = 6'd3;
        3'b101: w_idx = 6'd10;
        3'b110: w_idx = 6'd6;
        default: w_idx = 6'd14;
      endcase
      3'd4: case (r_stack[3:0])
        4'b0000: w_idx = 6'd7;
        4'b0001: w_idx = 6'd21;
        4'b0010: w_idx = 6'd5;
        4'b0100: w_idx = 6'd11;
        4'b0110: w_idx = 6'd15;
        4'b0111: w_idx = 6'd9;
        4'b1000: w_idx = 6'd1;
        4'b1001: w_idx = 6'd23;
        4'b1010: w_idx = 6'd2;
        4'b1011: w_idx = 6'd24;
        4'b1100: w_idx = 6'd25;
        4'b1101: w_idx = 6'd16;
        default: w_bad = 1'b1;
      endcase
      3'd5: case (r_stack)
        5'b11111: w_idx = 6'd26;
        5'b01111: w_idx = 6'd27;
        5'b00111: w_idx = 6'd28;
        5'b00011: w_idx = 6'd29;
        5'b00001: w_idx = 6'd30;
        5'b00000: w_idx = 6'd31;
        5'b10000: w_idx = 6'd32;
        5'b11000: w_idx = 6'd33;
        5'b11100: w_idx = 6'd34;
        5'b11110: w_idx = 6'd35;
        default: w_bad = 1'b1;
      endcase
      default: w_bad = 1'b1;
    endcase
    w_code = (r_count == 3'd0) ? BLANK : (r_ovf | w_bad) ? ERR : CHAR_W'(w_idx);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_state <= S_IDLE;
      r_stack <= '0;
      r_count <= '0;
      r_gap   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_disp  <= '1;
      r_code  <= BLANK;
    end else begin
      r_sync1 <= iKEY[4:1];
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= w_commit;
      if (w_commit) begin
        r_disp  <= {r_disp[DW-CHAR_W-1:0], w_code};
        r_code  <= w_code;
        r_state <= S_IDLE;
        r_stack <= '0;
        r_count <= '0;
        r_gap   <= '0;
        r_ovf   <= 1'b0;
      end else if (w_sym) begin
        r_state <= S_COLLECT;
        r_gap   <= '0;
        if (r_count < 3'(MAX_SYM)) begin
          r_stack <= {r_stack[3:0], w_dash};
          r_count <= r_count + 3'd1;
        end else r_ovf <= 1'b1;
      end else if (w_bs) begin
        if (r_state == S_COLLECT) begin
          r_state <= S_IDLE;
          r_stack <= '0;
          r_count <= '0;
          r_gap   <= '0;
          r_ovf   <= 1'b0;
        end else r_disp <= {BLANK, r_disp[DW-1:CHAR_W]};
      end else if (iEnable && r_state == S_COLLECT) r_gap <= r_gap + GW'(1);
    end
  end

  assign oDisplayData = r_disp;
  assign oCharValid   = r_valid;
  assign oCharCode    = r_code;
  assign oSymCount    = r_count;
  assign oOverflow    = r_ovf;
  assign oBuzzer      = iEnable & (~iKEY[1] | ~iKEY[2]);
endmodule
